// File: rtl/aap_fetch_if.sv
// aap_fetch_if: instruction-memory bus, redirect and decode handshake of the fetch stage
interface aap_fetch_if #(
    parameter int PC_WIDTH    = 16,
    parameter int COUNT_WIDTH = 16
);
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_rd;
    logic [15:0]            imem_rdata;
    logic                   redirect;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic                   fetch_valid;
    logic                   fetch_ready;
    logic [31:0]            fetch_instr;
    logic [PC_WIDTH-1:0]    fetch_pc;
    logic                   fetch_is32;
    logic [COUNT_WIDTH-1:0] fetch_count;

    modport master (
        output imem_addr, imem_rd, fetch_valid, fetch_instr, fetch_pc, fetch_is32, fetch_count,
        input  imem_rdata, redirect, redirect_pc, fetch_ready
    );

    modport slave (
        input  imem_addr, imem_rd, fetch_valid, fetch_instr, fetch_pc, fetch_is32, fetch_count,
        output imem_rdata, redirect, redirect_pc, fetch_ready
    );
endinterface

// File: rtl/aap_fetch_unit.sv
// aap_fetch_unit: fetches 16/32-bit AAP instructions from word memory and hands them to decode
module aap_fetch_unit #(
    parameter int                  PC_WIDTH    = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  COUNT_WIDTH = 16
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        step_en,
    aap_fetch_if.master bus
);
    typedef enum logic [2:0] {F1, W1, F2, W2, HOLD} state_t;

    state_t              state;
    logic [PC_WIDTH-1:0] pc;
    logic [15:0]         word0;
    logic                accept;

    assign accept = bus.fetch_valid & bus.fetch_ready;

    // fetch sequencer: redirect overrides every state; an accept is counted even when redirected
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state           <= F1;
            pc              <= RESET_PC;
            word0           <= '0;
            bus.imem_addr   <= '0;
            bus.imem_rd     <= 1'b0;
            bus.fetch_valid <= 1'b0;
            bus.fetch_instr <= '0;
            bus.fetch_pc    <= '0;
            bus.fetch_is32  <= 1'b0;
            bus.fetch_count <= '0;
        end else begin
            if (accept)
                bus.fetch_count <= bus.fetch_count + COUNT_WIDTH'(1);
            if (bus.redirect) begin
                pc              <= bus.redirect_pc;
                state           <= F1;
                bus.fetch_valid <= 1'b0;
                bus.imem_rd     <= 1'b0;
            end else begin
                case (state)
                    F1: if (step_en) begin
                        bus.imem_addr <= pc;
                        bus.imem_rd   <= 1'b1;
                        state         <= W1;
                    end
                    W1: begin
                        bus.imem_rd <= 1'b0;
                        word0       <= bus.imem_rdata;
                        if (bus.imem_rdata[15]) begin
                            state <= F2;
                        end else begin
                            bus.fetch_instr <= {16'h0000, bus.imem_rdata};
                            bus.fetch_is32  <= 1'b0;
                            bus.fetch_pc    <= pc;
                            bus.fetch_valid <= 1'b1;
                            state           <= HOLD;
                        end
                    end
                    F2: if (step_en) begin
                        bus.imem_addr <= pc + PC_WIDTH'(1);
                        bus.imem_rd   <= 1'b1;
                        state         <= W2;
                    end
                    W2: begin
                        bus.imem_rd     <= 1'b0;
                        bus.fetch_instr <= {word0, bus.imem_rdata};
                        bus.fetch_is32  <= 1'b1;
                        bus.fetch_pc    <= pc;
                        bus.fetch_valid <= 1'b1;
                        state           <= HOLD;
                    end
                    HOLD: if (accept) begin
                        bus.fetch_valid <= 1'b0;
                        pc              <= pc + (bus.fetch_is32 ? PC_WIDTH'(2) : PC_WIDTH'(1));
                        state           <= F1;
                    end
                    default: state <= F1;
                endcase
            end
        end
    end
endmodule

// File: doc/aap_fetch_unit.md
Name: aap_fetch_unit

Overview:
- Instruction fetch stage that feeds the core's decode state. It reads 16-bit words from a synchronous instruction memory and assembles 16-bit or 32-bit AAP instructions.
- Each instruction is presented to decode over a valid/ready handshake.
- Supports PC redirect from execute (branch/jump) with flush of any in-flight fetch.
- Runs on CLOCK_50. The request rate is throttled by a step enable generated by the core clock divider.

Parameters:
- PC_WIDTH, 16, word-address width of the program counter and imem address.
- RESET_PC, 16'h0000, PC value loaded on reset.
- COUNT_WIDTH, 16, width of the accepted-instruction counter.

Ports:
- CLOCK_50  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- step_en  input  1  advance enable; new memory requests are issued only on cycles where step_en=1.
- imem_addr  output  PC_WIDTH  word address to instruction memory.
- imem_rd  output  1  read strobe, single-cycle pulse.
- imem_rdata  input  16  read data, valid the CLOCK_50 cycle after imem_rd=1.
- redirect  input  1  load new PC and flush.
- redirect_pc  input  PC_WIDTH  target word address.
- fetch_valid  output  1  instruction available to decode.
- fetch_ready  input  1  decode accepts instruction.
- fetch_instr  output  32  instruction; 16-bit forms are zero-extended.
- fetch_pc  output  PC_WIDTH  address of first word of fetch_instr.
- fetch_is32  output  1  fetch_instr is a 32-bit instruction.
- fetch_count  output  COUNT_WIDTH  number of accepted instructions; wraps.

Behaviour:
- Reset (async):
  - state=F1, pc=RESET_PC.
  - imem_rd=0, imem_addr=0, fetch_valid=0, fetch_instr=0, fetch_pc=0, fetch_is32=0, fetch_count=0.
  - Reset mid-operation abandons any pending read; a returning imem_rdata is ignored.
- All outputs are registered.
- States:
  - F1: if step_en, then imem_addr<=pc, imem_rd<=1, go to W1. Otherwise stay in F1.
  - W1: imem_rd<=0; capture word0=imem_rdata unconditionally.
    - If word0[15]=1, go to F2 (32-bit instruction).
    - Else load fetch_instr={16'h0000,word0}, fetch_is32=0, fetch_pc=pc, fetch_valid=1, go to HOLD.
  - F2: if step_en, then imem_addr<=pc+1 (mod 2^PC_WIDTH), imem_rd<=1, go to W2.
  - W2: imem_rd<=0; fetch_instr={word0,imem_rdata}, fetch_is32=1, fetch_pc=pc, fetch_valid=1, go to HOLD.
  - HOLD:
    - While fetch_ready=0, fetch_valid, fetch_instr, fetch_pc and fetch_is32 stay stable and no imem_rd is issued.
    - On fetch_valid&fetch_ready: fetch_valid<=0, pc<=pc+(fetch_is32?2:1) mod 2^PC_WIDTH, fetch_count<=fetch_count+1 (wraps), go to F1.
- Minimum latency: imem_rd to fetch_valid is 1 cycle for a 16-bit instruction. A 32-bit instruction needs two additional cycles (its F2 cycle plus one), plus any step_en stall while waiting in F2.
- Redirect (any state, any cycle; highest priority):
  - pc<=redirect_pc, state<=F1, fetch_valid<=0, imem_rd<=0.
  - Data returning in that or the following cycle is discarded.
  - If redirect coincides with fetch_valid&fetch_ready, the transfer counts (fetch_count increments) but pc takes redirect_pc, not the increment.
- step_en low never drops a pending read. W1 and W2 always complete on the cycle after imem_rd.
- PC arithmetic is unsigned and wraps; a 32-bit instruction at pc=max fetches its second word from 0.

Test Plan:
- 16-bit fetch: RESET_PC=0, mem[0]=16'h1234, mem[1]=16'h0042, step_en=1, fetch_ready=1.
  - Required: imem_rd at addr 0, then fetch_valid with instr 32'h00001234, is32=0, pc=0.
  - Next request addr 1 gives instr 32'h00000042.
  - fetch_count=2.
- 32-bit fetch: redirect to 4, mem[4]=16'h8A01, mem[5]=16'h8003.
  - Required: reads at 4 then 5, fetch_instr=32'h8A018003, is32=1, fetch_pc=4.
  - Next read at addr 6.
- Backpressure: fetch_ready=0 for 5 cycles while valid.
  - Required: fetch_instr, fetch_pc and fetch_valid stable; imem_rd=0 throughout; fetch_count unchanged.
  - Raise fetch_ready: count increments once.
- Flush: redirect to 16'h0100 during W2 of a 32-bit fetch.
  - Required: no fetch_valid for the discarded instruction; next imem_addr=16'h0100.
  - Also check redirect coincident with an accept: count increments, next read at 16'h0100.
- Wrap: pc=16'hFFFF, mem[FFFF]=16'h8000, mem[0]=16'h0001.
  - Required: second read at addr 0, instr 32'h80000001.
  - After accept, next read at addr 1.
- Throttle/reset: step_en pulsed 1 in 4.
  - Required: imem_rd only on step_en cycles.
  - Assert reset during W1: all outputs 0 immediately; first read after release at RESET_PC.
